// File: rtl/render_pkg.sv
// Shared types and constants for the triangle model readers.
package render_pkg;

    localparam int unsigned VERT_W      = 6;
    localparam int unsigned COORD_N     = 3;
    localparam int unsigned ROM_WORD_W  = 54;
    localparam int unsigned VERTEX_BITS = VERT_W * COORD_N;

    // One vertex: element 0 = x, 1 = y, 2 = z, each a 6-bit signed coordinate.
    typedef logic signed [COORD_N-1:0][VERT_W-1:0] vertex_t;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StPresent,
        StDone
    } fetch_state_t;

endpackage

// File: rtl/vertex_unpack.sv
// Pure bit-slice of a model ROM word into three vertices; no arithmetic.
module vertex_unpack
    import render_pkg::*;
(
    input  logic [ROM_WORD_W-1:0] word_i,
    output vertex_t               v1_o,
    output vertex_t               v2_o,
    output vertex_t               v3_o
);

    // Word holds v1 in the top third; within a vertex x sits in the top field.
    always_comb begin
        v1_o = '0;
        v2_o = '0;
        v3_o = '0;
        for (int c = 0; c < COORD_N; c++) begin
            v1_o[c] = word_i[2*VERTEX_BITS + (COORD_N-1-c)*VERT_W +: VERT_W];
            v2_o[c] = word_i[1*VERTEX_BITS + (COORD_N-1-c)*VERT_W +: VERT_W];
            v3_o[c] = word_i[0*VERTEX_BITS + (COORD_N-1-c)*VERT_W +: VERT_W];
        end
    end

endmodule

// File: rtl/tri_fetch.sv
// Walks the triangle model ROM once per start pulse and presents each
// triangle's vertices on a valid/ready interface.
module tri_fetch
    import render_pkg::*;
#(
    parameter int unsigned NUM_TRIS = 12,
    parameter int unsigned IDX_W    = (NUM_TRIS > 1) ? $clog2(NUM_TRIS) : 1,
    parameter int unsigned ROM_LAT  = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  start_in,
    output logic [IDX_W-1:0]      rom_addr_out,
    input  logic [ROM_WORD_W-1:0] rom_data_in,
    output vertex_t               v1_out,
    output vertex_t               v2_out,
    output vertex_t               v3_out,
    output logic [IDX_W-1:0]      tri_idx_out,
    output logic                  tri_valid_out,
    input  logic                  tri_ready_in,
    output logic                  tri_last_out,
    output logic                  busy_out,
    output logic                  done_out
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TRIS - 1);
    localparam logic [1:0]       LAT_INIT = 2'(ROM_LAT - 1);

    fetch_state_t     state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    logic [1:0]       cnt_q;
    vertex_t          v1_q, v2_q, v3_q;
    vertex_t          u1, u2, u3;
    logic             is_last;

    assign is_last = (idx_q == LAST_IDX);

    vertex_unpack u_unpack (
        .word_i (rom_data_in),
        .v1_o   (u1),
        .v2_o   (u2),
        .v3_o   (u3)
    );

    // State register.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only honoured from idle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start_in) state_d = StIssue;
            StIssue:   state_d = StWait;
            StWait:    if (cnt_q == 2'd0) state_d = StPresent;
            StPresent: if (tri_ready_in) state_d = is_last ? StDone : StIssue;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Index, latency counter and captured vertices.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            idx_q <= '0;
            cnt_q <= '0;
            v1_q  <= '0;
            v2_q  <= '0;
            v3_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_in) idx_q <= '0;
                end
                StIssue: begin
                    cnt_q <= LAT_INIT;
                end
                StWait: begin
                    // Counter at zero means ROM data for idx_q is on rom_data_in now.
                    if (cnt_q == 2'd0) begin
                        v1_q <= u1;
                        v2_q <= u2;
                        v3_q <= u3;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                StPresent: begin
                    if (tri_ready_in && !is_last) idx_q <= idx_q + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state; address and vertices come straight from registers.
    always_comb begin
        tri_valid_out = 1'b0;
        tri_last_out  = 1'b0;
        busy_out      = 1'b0;
        done_out      = 1'b0;
        unique case (state_q)
            StIdle:    ;
            StIssue:   busy_out = 1'b1;
            StWait:    busy_out = 1'b1;
            StPresent: begin
                busy_out      = 1'b1;
                tri_valid_out = 1'b1;
                tri_last_out  = is_last;
            end
            StDone: begin
                busy_out = 1'b1;
                done_out = 1'b1;
            end
            default: ;
        endcase
    end

    assign rom_addr_out = idx_q;
    assign tri_idx_out  = idx_q;
    assign v1_out       = v1_q;
    assign v2_out       = v2_q;
    assign v3_out       = v3_q;

endmodule
